// File: rtl/hilo_mdu.sv
// HI/LO register pair with a multi-cycle multiply/accumulate and restoring divide engine.
// MFHI/MFLO reads stall while the engine is busy; flush aborts an in-flight op.
module hilo_mdu #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             op_ready,
    output logic             busy,
    output logic             done,
    input  logic             flush,
    input  logic             rd_en,
    input  logic             rd_hi,
    output logic             rd_stall,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q
);
    localparam int CMAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [2:0] OP_MULT  = 3'b000, OP_MULTU = 3'b001, OP_DIV  = 3'b010,
                           OP_DIVU  = 3'b011, OP_MTHI  = 3'b100, OP_MTLO = 3'b101,
                           OP_MADD  = 3'b110, OP_MSUB  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t               r_state, w_nxt;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_op;
    logic [WIDTH-1:0]     r_a, r_b;
    logic [WIDTH-1:0]     r_rem, r_quo, r_dvs;
    logic                 r_neg_q, r_neg_r, r_dz;
    logic [WIDTH-1:0]     r_hi, r_lo, r_rd;
    logic                 r_done;

    logic                 w_busy, w_acc, w_mul_fin, w_div_fin;
    logic                 w_msgn, w_sdiv, w_a_neg, w_b_neg, w_ge;
    logic [2*WIDTH-1:0]   w_pa, w_pb, w_prod, w_mres;
    logic [WIDTH:0]       w_shift, w_diff;
    logic [WIDTH-1:0]     w_q_fix, w_r_fix;

    assign w_busy    = (r_state != S_IDLE);
    assign w_acc     = op_valid && !w_busy && !flush;
    assign w_mul_fin = (r_state == S_MUL) && (r_cnt == '0) && !flush;
    assign w_div_fin = (r_state == S_FIX) && !flush;

    assign busy     = w_busy;
    assign op_ready = !w_busy && !rst;
    assign done     = r_done;
    assign rd_stall = rd_en && w_busy;
    assign rd_data  = r_rd;
    assign hi_q     = r_hi;
    assign lo_q     = r_lo;

    // Only MULTU is unsigned; MADD/MSUB accumulate a signed product.
    assign w_msgn = (r_op != OP_MULTU);
    assign w_pa   = w_msgn ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    assign w_pb   = w_msgn ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    assign w_prod = w_pa * w_pb;

    always_comb begin
        w_mres = w_prod;
        if (r_op == OP_MADD)      w_mres = {r_hi, r_lo} + w_prod;
        else if (r_op == OP_MSUB) w_mres = {r_hi, r_lo} - w_prod;
    end

    assign w_sdiv  = (op == OP_DIV);
    assign w_a_neg = w_sdiv && src_a[WIDTH-1];
    assign w_b_neg = w_sdiv && src_b[WIDTH-1];

    // Restoring step: bit WIDTH of the difference is the borrow.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_ge    = !w_diff[WIDTH];
    assign w_q_fix = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix = r_neg_r ? -r_rem : r_rem;

    always_comb begin
        w_nxt = r_state;
        if (flush) w_nxt = S_IDLE;
        else begin
            case (r_state)
                S_IDLE: if (op_valid) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: w_nxt = S_MUL;
                        OP_DIV, OP_DIVU:                     w_nxt = S_DIV;
                        default:                             w_nxt = S_IDLE;
                    endcase
                end
                S_MUL:   if (r_cnt == '0) w_nxt = S_IDLE;
                S_DIV:   if (r_cnt == '0) w_nxt = S_FIX;
                S_FIX:   w_nxt = S_IDLE;
                default: w_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0; r_op <= '0; r_a <= '0; r_b <= '0;
            r_rem <= '0; r_quo <= '0; r_dvs <= '0;
            r_neg_q <= 1'b0; r_neg_r <= 1'b0; r_dz <= 1'b0;
            r_hi <= '0; r_lo <= '0; r_rd <= '0; r_done <= 1'b0;
        end else begin
            r_done <= w_mul_fin || w_div_fin;
            if (rd_en && !w_busy) r_rd <= rd_hi ? r_hi : r_lo;

            if (w_acc) begin
                r_op <= op;
                r_a  <= src_a;
                r_b  <= src_b;
                case (op)
                    OP_MTHI: r_hi <= src_a;
                    OP_MTLO: r_lo <= src_a;
                    OP_DIV, OP_DIVU: begin
                        r_cnt   <= CW'(WIDTH - 1);
                        r_rem   <= '0;
                        r_quo   <= w_a_neg ? -src_a : src_a;
                        r_dvs   <= w_b_neg ? -src_b : src_b;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_dz    <= (src_b == '0);
                    end
                    default: r_cnt <= CW'(MUL_LAT - 1);
                endcase
            end

            if (r_state == S_MUL && r_cnt != '0) r_cnt <= r_cnt - CW'(1);
            if (r_state == S_DIV) begin
                if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
                r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], w_ge};
            end

            if (w_mul_fin) {r_hi, r_lo} <= w_mres;
            if (w_div_fin) begin
                if (r_dz) begin
                    r_lo <= '1;
                    r_hi <= r_a;
                end else begin
                    r_lo <= w_q_fix;
                    r_hi <= w_r_fix;
                end
            end
        end
    end
endmodule

// File: tb/tb_hilo_mdu.sv
// Directed bench for hilo_mdu (WIDTH=32, MUL_LAT=2) with hand-computed expectations.
module tb_hilo_mdu;
    logic        clk = 1'b0, rst = 1'b1;
    logic        op_valid = 1'b0, flush = 1'b0, rd_en = 1'b0, rd_hi = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] src_a = '0, src_b = '0;
    logic        op_ready, busy, done, rd_stall;
    logic [31:0] rd_data, hi_q, lo_q;
    int          n_vec = 0, n_err = 0;

    hilo_mdu #(.WIDTH(32), .MUL_LAT(2)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .src_a(src_a), .src_b(src_b),
        .op_ready(op_ready), .busy(busy), .done(done), .flush(flush), .rd_en(rd_en),
        .rd_hi(rd_hi), .rd_stall(rd_stall), .rd_data(rd_data), .hi_q(hi_q), .lo_q(lo_q)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1; op = o; src_a = a; src_b = b;
        tick();
        op_valid = 1'b0;
    endtask

    // Accept an op, count busy cycles (bounded), then expect the done pulse.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int exp_cyc, input string tag);
        int c;
        issue(o, a, b);
        c = 0;
        while (busy && c < 200) begin
            c++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 64'(c), 64'(exp_cyc));
        chk({tag, "_done"}, 64'(done), 64'd1);
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_hi", 64'(hi_q), 64'h0);
        chk("rst_lo", 64'(lo_q), 64'h0);
        chk("rst_rd", 64'(rd_data), 64'h0);
        chk("rst_busy_done", {busy, done}, 64'h0);
        chk("rst_op_ready_in_rst", 64'(op_ready), 64'h0);
        rst = 1'b0; #1;
        chk("op_ready_idle", 64'(op_ready), 64'h1);

        // 1. MTHI then read back
        issue(3'b100, 32'h1234_5678, '0);
        chk("mthi_no_done", {busy, done}, 64'h0);
        rd_en = 1'b1; rd_hi = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("mfhi", 64'(rd_data), 64'h1234_5678);

        // asynchronous reset during MUL
        issue(3'b000, 32'd3, 32'd4);
        chk("mul_busy", 64'(busy), 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_hilo", {hi_q, lo_q}, 64'h0);
        chk("async_rst_busy", 64'(busy), 64'h0);
        #1 rst = 1'b0;
        tick();

        // 2. multiplies
        run_op(3'b001, 32'hFFFF_FFFF, 32'h2, 2, "multu");
        chk("multu_res", {hi_q, lo_q}, 64'h0000_0001_FFFF_FFFE);
        tick();
        chk("done_pulse_one_cycle", 64'(done), 64'h0);
        run_op(3'b000, 32'hFFFF_FFFF, 32'h2, 2, "mult");
        chk("mult_res", {hi_q, lo_q}, 64'hFFFF_FFFF_FFFF_FFFE);

        // 3. divides
        run_op(3'b010, 32'hFFFF_FFF9, 32'h2, 33, "div_m7_2");
        chk("div_m7_2_res", {hi_q, lo_q}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'b011, 32'd100, 32'd7, 33, "divu_100_7");
        chk("divu_100_7_res", {hi_q, lo_q}, {32'd2, 32'd14});
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 33, "div_ovf");
        chk("div_ovf_res", {hi_q, lo_q}, 64'h0000_0000_8000_0000);

        // 4. divide by zero
        run_op(3'b011, 32'd5, 32'd0, 33, "divu_by0");
        chk("divu_by0_res", {hi_q, lo_q}, {32'd5, 32'hFFFF_FFFF});
        run_op(3'b010, 32'hFFFF_FFF9, 32'd0, 33, "div_by0");
        chk("div_by0_res", {hi_q, lo_q}, {32'hFFFF_FFF9, 32'hFFFF_FFFF});

        // 5. accumulate
        issue(3'b100, 32'd0, '0);
        issue(3'b101, 32'd10, '0);
        run_op(3'b110, 32'd3, 32'd4, 2, "madd");
        chk("madd_res", {hi_q, lo_q}, 64'd22);
        run_op(3'b111, 32'd5, 32'd5, 2, "msub");
        chk("msub_res", {hi_q, lo_q}, 64'hFFFF_FFFF_FFFF_FFFD);
        // read issued on the done cycle sees the new value
        rd_en = 1'b1; rd_hi = 1'b0;
        tick();
        chk("rd_on_done", 64'(rd_data), 64'hFFFF_FFFD);
        // read and MTLO in the same cycle: old value first
        op_valid = 1'b1; op = 3'b101; src_a = 32'h55;
        tick();
        op_valid = 1'b0;
        chk("rd_same_cycle_mtlo", 64'(rd_data), 64'hFFFF_FFFD);
        tick();
        rd_en = 1'b0;
        chk("rd_after_mtlo", 64'(rd_data), 64'h55);

        // 6. flush mid-divide
        issue(3'b100, 32'hAA, '0);
        issue(3'b101, 32'hBB, '0);
        issue(3'b010, 32'd100, 32'd7);          // now in busy cycle 1
        tick();                                  // busy cycle 2
        rd_en = 1'b1; rd_hi = 1'b1; #1;
        chk("rd_stall", 64'(rd_stall), 64'h1);
        tick();                                  // busy cycle 3
        rd_en = 1'b0;
        chk("rd_hold_busy", 64'(rd_data), 64'h55);
        op_valid = 1'b1; op = 3'b100; src_a = 32'hDEAD; #1;
        chk("op_ready_busy", 64'(op_ready), 64'h0);
        tick();                                  // busy cycle 4
        op_valid = 1'b0;
        repeat (6) tick();                       // busy cycle 10
        chk("still_busy_c10", 64'(busy), 64'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle", {busy, done}, 64'h0);
        chk("flush_hilo", {hi_q, lo_q}, {32'hAA, 32'hBB});
        repeat (3) tick();
        chk("flush_no_late_done", {done, hi_q, lo_q}, {1'b0, 32'hAA, 32'hBB});

        // flush in IDLE blocks acceptance
        op_valid = 1'b1; op = 3'b100; src_a = 32'h77; flush = 1'b1;
        tick();
        op_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_no_accept", {busy, hi_q}, {1'b0, 32'hAA});

        // flush on the final multiply edge wins
        issue(3'b001, 32'd6, 32'd7);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_final_edge", {busy, done, hi_q, lo_q}, {2'b00, 32'hAA, 32'hBB});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
